load_store_unit: RTL

//  Memory-side responder to the main decoder's memory controls (memReq/memWrite/funct3).

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_if.sv | 29 ++
 rtl/lsu_align.sv | 59 +++++
 rtl/load_store_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the load/store unit.
//   state_t        : FSM states IDLE -> REQ -> (WAIT) -> DONE -> IDLE
//   F3_*           : RV32I funct3 encodings for loads and stores
//   BE_*           : unshifted byte-enable patterns per access size
//   is_misaligned  : size/alignment check, used only when the
//                    LSU_MISALIGN_TRAP_EN build option is defined
// ---------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 16;

  // Reserved sizes (011, 11x) are treated as word accesses.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_bus_if
// Data-memory bus between the load/store unit (master) and dmem (slave).
// Handshake: a request transfers on the cycle where valid & ready are both 1;
// the master holds valid, we, addr, wdata and be stable until that cycle.
// Read data returns on a cycle with rvalid=1, either together with ready or
// on a later cycle; the master never back-pressures rvalid.
//   valid  m->s  request valid
//   ready  s->m  request accepted
//   we     m->s  write strobe
//   addr   m->s  word address (low two bits zero)
//   wdata  m->s  lane-replicated store data
//   be     m->s  byte enables
//   rvalid s->m  read data valid
//   rdata  s->m  read word
// ---------------------------------------------------------------------------
interface lsu_bus_if;
  logic        valid;
  logic        ready;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output valid, we, addr, wdata, be, input ready, rvalid, rdata);
  modport slave  (input valid, we, addr, wdata, be, output ready, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align (combinational)
// Byte-enable and write-data lane generation for stores, and byte/half
// extraction with sign or zero extension for loads.
//   i_funct3     access size/sign
//   i_addr_lo    byte offset within the word
//   i_wdata      store data, low bytes significant
//   i_rdata      raw word from the bus
//   o_be         byte enables
//   o_wdata      store data replicated across all lanes of its size
//   o_rdata_ext  extracted and extended load data
// ---------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata_ext
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unsigned;

  always_comb begin
    w_shift    = i_rdata >> {i_addr_lo, 3'b000};
    w_byte     = w_shift[7:0];
    // Halfwords use only a[1]; a[0] is ignored when misaligned.
    w_half     = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    w_unsigned = i_funct3[2];

    o_be        = BE_WORD;
    o_wdata     = i_wdata;
    o_rdata_ext = i_rdata;
    case (i_funct3[1:0])
      2'b00: begin
        o_be        = BE_BYTE << i_addr_lo;
        o_wdata     = {4{i_wdata[7:0]}};
        o_rdata_ext = w_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      2'b01: begin
        o_be        = BE_HALF << {i_addr_lo[1], 1'b0};
        o_wdata     = {2{i_wdata[15:0]}};
        o_rdata_ext = w_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: begin
        o_be        = BE_WORD;
        o_wdata     = i_wdata;
        o_rdata_ext = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Turns one RV32I load/store request from the main decoder into one
// transaction on the data-memory bus and stalls the core until it completes.
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, misaligned H/W accesses
// skip the bus and complete with o_busErr; otherwise low address bits below
// the access size are ignored.
// Parameter: TIMEOUT_CYCLES -- REQ+WAIT cycles before abort (0 = no timeout).
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_memReq            request, held while o_stall=1
//   i_memWrite          1 = store, 0 = load
//   i_funct3            size/sign
//   i_addr              byte address
//   i_writeData         store data
//   o_stall             hold the pipeline
//   o_done              one-cycle completion pulse
//   o_readData          extended load data, valid with o_done on loads
//   o_busErr            one-cycle abort pulse with o_done
//   o_state             current FSM state (debug)
//   bus                 data-memory bus, master side
// ---------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_memReq,
  input  logic        i_memWrite,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_writeData,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_readData,
  output logic        o_busErr,
  output state_t      o_state,
  lsu_bus_if.master   bus
);

  localparam logic [15:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_state_next;
  logic [31:0] r_addr, r_wdata, r_read_data;
  logic [2:0]  r_funct3;
  logic        r_we, r_err;
  logic [15:0] r_cnt, w_cnt_next;

  logic        w_stall, w_bus_valid, w_capture, w_err_set, w_timeout, w_in_bus;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_rdata_ext;

  lsu_align u_align (
    .i_funct3    (r_funct3),
    .i_addr_lo   (r_addr[1:0]),
    .i_wdata     (r_wdata),
    .i_rdata     (bus.rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_rdata_ext (w_rdata_ext)
  );

  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);
  assign w_in_bus  = (r_state == REQ) || (r_state == WAIT);

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_bus_valid  = 1'b0;
    w_capture    = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_memReq) begin
          w_stall      = 1'b1;
          w_state_next = REQ;
`ifdef LSU_MISALIGN_TRAP_EN
          if (is_misaligned(i_funct3, i_addr[1:0])) begin
            w_state_next = DONE;
            w_err_set    = 1'b1;
          end
`endif
        end
      end
      REQ: begin
        w_stall     = 1'b1;
        w_bus_valid = 1'b1;
        if (bus.ready) begin
          if (r_we) begin
            w_state_next = DONE;
          end else if (bus.rvalid) begin
            w_capture    = 1'b1;
            w_state_next = DONE;
          end else begin
            w_state_next = WAIT;
          end
        end else if (w_timeout) begin
          w_err_set    = 1'b1;
          w_state_next = DONE;
        end
      end
      WAIT: begin
        w_stall = 1'b1;
        if (bus.rvalid) begin
          w_capture    = 1'b1;
          w_state_next = DONE;
        end else if (w_timeout) begin
          w_err_set    = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        // i_memReq may still be high here; it is the finished instruction.
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase

    // Counter spans REQ and WAIT of one transaction; restarts at 0 in REQ.
    w_cnt_next = 16'd0;
    if (w_in_bus && ((w_state_next == REQ) || (w_state_next == WAIT)))
      w_cnt_next = r_cnt + 16'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_funct3    <= 3'd0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_read_data <= 32'd0;
      r_cnt       <= 16'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_set;
      if (r_state == IDLE && i_memReq) begin
        r_addr   <= i_addr;
        r_wdata  <= i_writeData;
        r_funct3 <= i_funct3;
        r_we     <= i_memWrite;
      end
      if (w_capture)
        r_read_data <= w_rdata_ext;
      else if (w_err_set)
        r_read_data <= 32'd0;
    end
  end

  // Stall is gated by reset so it drops in the same cycle reset asserts,
  // even while the decoder is still holding i_memReq.
  assign o_stall    = w_stall & ~i_rst;
  assign o_done     = (r_state == DONE);
  assign o_busErr   = r_err;
  assign o_readData = r_read_data;
  assign o_state    = r_state;

  assign bus.valid = w_bus_valid;
  assign bus.we    = w_bus_valid & r_we;
  assign bus.addr  = w_bus_valid ? {r_addr[31:2], 2'b00} : 32'd0;
  assign bus.wdata = w_bus_valid ? w_wdata : 32'd0;
  assign bus.be    = w_bus_valid ? w_be : 4'd0;

endmodule
